// File: rtl/gen_sched_pkg.sv
// -----------------------------------------------------------------------------
// gen_sched_pkg
//   Shared constants for the generator sequencer and anything that decodes its
//   state (e.g. the display driver).
//   - state_t : run-control state encoding (IDLE/RUN/PAUSE/SWITCH = 0..3)
//   - GEN_T / GEN_F : generator identifiers used for 'active' and the owner
//                     of an outstanding request
// -----------------------------------------------------------------------------
package gen_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_SWITCH = 2'd3
    } state_t;

    localparam logic GEN_T = 1'b0;
    localparam logic GEN_F = 1'b1;

endpackage

// File: rtl/gen_sched_rise_det.sv
// -----------------------------------------------------------------------------
// rise_det
//   Rising-edge detector for a level button.
//   Ports:
//     i_clk   - system clock
//     i_rst   - synchronous active-high reset (clears the registered prev)
//     i_btn   - level input
//     o_pulse - combinational pulse, high while i_btn is high and the
//               previously sampled level was low
//   A button held high through reset must not look like a fresh press, so the
//   detector stays disarmed until it has sampled the button low at least once
//   (the arm bit loads the inverted level while reset is asserted).
// -----------------------------------------------------------------------------
module rise_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_prev;
    logic r_armed;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev  <= 1'b0;
            r_armed <= ~i_btn;
        end else begin
            r_prev <= i_btn;
            if (!i_btn) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_pulse = i_btn & ~r_prev & r_armed;

endmodule

// File: rtl/gen_sched.sv
// -----------------------------------------------------------------------------
// gen_sched
//   Run-control sequencer sharing one 16-bit result path between a timer (T)
//   and a second generator (F).
//   Ports:
//     clk, rst           - clock, synchronous active-high reset
//     start/stop/pause/sel - level buttons, acted on at their rising edge
//     t_valid/t_out      - timer result handshake
//     f_valid/f_out      - second generator result handshake
//     t_en/f_en          - one-cycle enable strobes (registered)
//     data_out/data_valid - captured result and its one-cycle update pulse
//     active             - selected generator (GEN_T/GEN_F)
//     state              - run-control state (state_t encoding)
//     err                - sticky response-timeout flag
//
//   Request protocol: a strobe on t_en/f_en opens one outstanding request owned
//   by that generator. The request is closed by the owner's valid (result is
//   captured) or by the timeout (err is set). Only one request is ever
//   outstanding; valids from the non-owner or with nothing outstanding are
//   dropped. A valid on the timeout cycle wins over the timeout.
// -----------------------------------------------------------------------------
module gen_sched
    import gen_sched_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int TIMEOUT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic        sel,
    input  logic        t_valid,
    input  logic [15:0] t_out,
    input  logic        f_valid,
    input  logic [15:0] f_out,
    output logic        t_en,
    output logic        f_en,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        active,
    output logic [1:0]  state,
    output logic        err
);

    localparam int             TW        = $clog2(TICK_DIV);
    localparam int             OW        = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [OW-1:0]  TMO_LAST  = OW'(TIMEOUT - 1);

    // Button edge pulses
    logic w_start_p;
    logic w_stop_p;
    logic w_pause_p;
    logic w_sel_p;

    rise_det u_start (.i_clk(clk), .i_rst(rst), .i_btn(start), .o_pulse(w_start_p));
    rise_det u_stop  (.i_clk(clk), .i_rst(rst), .i_btn(stop),  .o_pulse(w_stop_p));
    rise_det u_pause (.i_clk(clk), .i_rst(rst), .i_btn(pause), .o_pulse(w_pause_p));
    rise_det u_sel   (.i_clk(clk), .i_rst(rst), .i_btn(sel),   .o_pulse(w_sel_p));

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_tick;
    logic [OW-1:0]   r_tmo;
    logic            r_pending;
    logic            r_owner;
    logic            r_active;
    logic [15:0]     r_data;
    logic            r_dvalid;
    logic            r_t_en;
    logic            r_f_en;
    logic            r_err;

    // Request resolution, evaluated against the request owner only
    logic        w_owner_valid;
    logic [15:0] w_owner_data;
    logic        w_accept;
    logic        w_timeout;
    logic        w_resolved;
    logic        w_stop_clr;

    assign w_owner_valid = (r_owner == GEN_F) ? f_valid : t_valid;
    assign w_owner_data  = (r_owner == GEN_F) ? f_out   : t_out;
    assign w_accept      = r_pending & w_owner_valid;
    assign w_timeout     = r_pending & ~w_owner_valid & (r_tmo == TMO_LAST);
    // SWITCH may complete once nothing is outstanding after this edge
    assign w_resolved    = ~r_pending | w_accept | w_timeout;
    assign w_stop_clr    = (r_state != ST_IDLE) && (w_next == ST_IDLE);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // Priority on simultaneous pulses: stop > sel > pause > start.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_p) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_stop_p)       w_next = ST_IDLE;
                else if (w_sel_p)   w_next = ST_SWITCH;
                else if (w_pause_p) w_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (w_stop_p)       w_next = ST_IDLE;
                else if (w_pause_p) w_next = ST_RUN;
            end
            ST_SWITCH: begin
                if (w_stop_p)        w_next = ST_IDLE;
                else if (w_resolved) w_next = ST_RUN;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: output decode ----------------
    logic w_strobe;
    logic w_tick_clr;
    logic w_tick_run;
    logic w_toggle;
    logic w_err_clr;

    always_comb begin
        w_strobe   = 1'b0;
        w_tick_clr = 1'b0;
        w_tick_run = 1'b0;
        w_toggle   = 1'b0;
        w_err_clr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_next == ST_RUN) begin
                    w_tick_clr = 1'b1;
                    w_err_clr  = 1'b1;
                end
            end
            ST_RUN: begin
                // The counter keeps running on the cycle RUN is left, so a
                // pause/resume pair continues from where it stopped. A strobe
                // is only issued if RUN is kept, so the enables stay low in
                // PAUSE/SWITCH/IDLE. 'Pending' is the pre-edge value: a valid
                // that closes a request on the tick edge still skips that tick.
                w_tick_run = 1'b1;
                if ((w_next == ST_RUN) && (r_tick == TICK_LAST) && !r_pending) begin
                    w_strobe = 1'b1;
                end
            end
            ST_SWITCH: begin
                if (w_next == ST_RUN) begin
                    w_toggle   = 1'b1;
                    w_tick_clr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick    <= '0;
            r_tmo     <= '0;
            r_pending <= 1'b0;
            r_owner   <= GEN_T;
            r_active  <= GEN_T;
            r_data    <= 16'h0000;
            r_dvalid  <= 1'b0;
            r_t_en    <= 1'b0;
            r_f_en    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_tick_clr) begin
                r_tick <= '0;
            end else if (w_tick_run) begin
                r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + TW'(1);
            end

            r_t_en <= w_strobe & (r_active == GEN_T);
            r_f_en <= w_strobe & (r_active == GEN_F);

            if (w_strobe) begin
                r_pending <= 1'b1;
                r_owner   <= r_active;
                r_tmo     <= '0;
            end else if (w_stop_clr || w_accept || w_timeout) begin
                r_pending <= 1'b0;
                r_tmo     <= '0;
            end else if (r_pending) begin
                r_tmo <= r_tmo + OW'(1);
            end

            if (w_accept) begin
                r_data <= w_owner_data;
            end
            r_dvalid <= w_accept;

            if (w_err_clr) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end

            if (w_toggle) begin
                r_active <= ~r_active;
            end
        end
    end

    assign t_en       = r_t_en;
    assign f_en       = r_f_en;
    assign data_out   = r_data;
    assign data_valid = r_dvalid;
    assign active     = r_active;
    assign state      = r_state;
    assign err        = r_err;

endmodule

// File: tb/tb_gen_sched.sv
// -----------------------------------------------------------------------------
// tb_gen_sched
//   Self-checking bench for gen_sched: reset check, a vector table for the
//   basic strobe/capture rhythm, hand sequences for switch/timeout/pause/stop/
//   reset corners, and a randomized run. Every clock a behavioural model
//   (cycles-in-run count, request deadline, last-seen button levels) predicts
//   all outputs.
// -----------------------------------------------------------------------------
module tb_gen_sched;

    localparam int TICK_DIV = 4;
    localparam int TIMEOUT  = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic        pause = 1'b0;
    logic        sel   = 1'b0;
    logic        t_valid = 1'b0;
    logic [15:0] t_out   = 16'h0000;
    logic        f_valid = 1'b0;
    logic [15:0] f_out   = 16'h0000;
    logic        t_en;
    logic        f_en;
    logic [15:0] data_out;
    logic        data_valid;
    logic        active;
    logic [1:0]  state;
    logic        err;

    gen_sched #(.TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .start(start), .stop(stop), .pause(pause), .sel(sel),
        .t_valid(t_valid), .t_out(t_out),
        .f_valid(f_valid), .f_out(f_out),
        .t_en(t_en), .f_en(f_en),
        .data_out(data_out), .data_valid(data_valid),
        .active(active), .state(state), .err(err)
    );

    int n_total = 0;
    int n_bad   = 0;

    // ---------------- behavioural model ----------------
    int          m_state;
    logic        m_active, m_err, m_dv, m_ten, m_fen;
    logic [15:0] m_data;
    logic        m_pend, m_owner;
    int          m_runc;
    longint      m_cyc = 0;
    longint      m_deadline;
    logic        m_last [4];

    // Called once per clock edge with the inputs that edge sampled.
    task automatic model_edge();
        logic b [4];
        logic p [4];
        logic hit, tmo, pend_before, strobe;
        int   nxt;
        b[0] = start; b[1] = stop; b[2] = pause; b[3] = sel;
        m_cyc++;
        if (rst) begin
            m_state = 0; m_active = 1'b0; m_err = 1'b0; m_dv = 1'b0;
            m_ten = 1'b0; m_fen = 1'b0; m_data = 16'h0000;
            m_pend = 1'b0; m_owner = 1'b0; m_runc = 0; m_deadline = 0;
            // a level present during reset counts as already seen
            for (int i = 0; i < 4; i++) m_last[i] = b[i];
            return;
        end
        for (int i = 0; i < 4; i++) begin
            p[i] = b[i] & ~m_last[i];
            m_last[i] = b[i];
        end
        pend_before = m_pend;
        hit = m_pend && (m_owner ? f_valid : t_valid);
        tmo = m_pend && !hit && (m_cyc == m_deadline);
        m_dv = hit;
        if (hit) m_data = m_owner ? f_out : t_out;
        if (tmo) m_err = 1'b1;
        if (hit || tmo) m_pend = 1'b0;
        strobe = 1'b0;
        nxt = m_state;
        case (m_state)
            0: if (p[0]) begin nxt = 1; m_err = 1'b0; m_runc = 0; end
            1: begin
                if (p[1])      nxt = 0;
                else if (p[3]) nxt = 3;
                else if (p[2]) nxt = 2;
                else if ((m_runc % TICK_DIV) == TICK_DIV - 1 && !pend_before) strobe = 1'b1;
                m_runc++;
            end
            2: begin
                if (p[1])      nxt = 0;
                else if (p[2]) nxt = 1;
            end
            default: begin
                if (p[1]) nxt = 0;
                else if (!pend_before || hit || tmo) begin
                    nxt = 1; m_active = ~m_active; m_runc = 0;
                end
            end
        endcase
        if (nxt == 0 && m_state != 0) m_pend = 1'b0;
        m_ten = strobe & ~m_active;
        m_fen = strobe & m_active;
        if (strobe) begin
            m_pend = 1'b1;
            m_owner = m_active;
            m_deadline = m_cyc + TIMEOUT;
        end
        m_state = nxt;
    endtask

    // ---------------- driver / scoreboard ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock: inputs as currently driven are sampled at the edge, outputs
    // are checked 1 time unit later against the model.
    task automatic cycle();
        logic [22:0] got, exp;
        @(posedge clk);
        #1;
        model_edge();
        got = {state, active, err, t_en, f_en, data_valid, data_out};
        exp = {m_state[1:0], m_active, m_err, m_ten, m_fen, m_dv, m_data};
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL model cyc=%0d got=%h want=%h", m_cyc, got, exp);
        end
        n_total++;
        if ((t_en & f_en) !== 1'b0) begin
            n_bad++;
            $display("FAIL en_excl cyc=%0d t_en=%b f_en=%b want not both", m_cyc, t_en, f_en);
        end
    endtask

    typedef struct {
        logic        start;
        logic        tv;
        logic [15:0] td;
        logic        e_ten;
        logic        e_dv;
        logic [15:0] e_data;
        logic [1:0]  e_state;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic found;

        // T strobed every TICK_DIV clocks, answering the cycle after t_en
        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'd1};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'd1};
        tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'd1};
        tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'd1};
        tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 2'd1};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'd1};
        tbl[6]  = '{1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 16'h0001, 2'd1};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 2'd1};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 2'd1};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 2'd1};
        tbl[10] = '{1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 16'h0002, 2'd1};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0002, 2'd1};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 2'd1};

        // ---- reset values ----
        rst = 1'b1;
        cycle();
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_data", data_out, 16'h0000);
        chk("rst_flags", 16'({active, err, t_en, f_en, data_valid}), 16'd0);
        rst = 1'b0;
        cycle();
        cycle();

        // ---- vector table ----
        for (int i = 0; i < 13; i++) begin
            start   = tbl[i].start;
            t_valid = tbl[i].tv;
            t_out   = tbl[i].td;
            cycle();
            chk($sformatf("tbl%0d_ten", i), 16'(t_en), 16'(tbl[i].e_ten));
            chk($sformatf("tbl%0d_fen", i), 16'(f_en), 16'd0);
            chk($sformatf("tbl%0d_dv", i), 16'(data_valid), 16'(tbl[i].e_dv));
            chk($sformatf("tbl%0d_data", i), data_out, tbl[i].e_data);
            chk($sformatf("tbl%0d_state", i), 16'(state), 16'(tbl[i].e_state));
        end
        t_valid = 1'b0;

        // ---- sel while a T request is outstanding ----
        sel = 1'b1;
        cycle();
        chk("sw_state0", 16'(state), 16'd3);
        sel = 1'b0;
        cycle();
        chk("sw_state1", 16'(state), 16'd3);
        t_valid = 1'b1; t_out = 16'h0005;
        cycle();
        t_valid = 1'b0;
        chk("sw_state2", 16'(state), 16'd1);
        chk("sw_data", data_out, 16'h0005);
        chk("sw_active", 16'(active), 16'd1);
        for (int i = 1; i <= 4; i++) begin
            cycle();
            chk($sformatf("sw_en%0d", i), 16'({t_en, f_en}), (i == 4) ? 16'd1 : 16'd0);
        end

        // ---- F never answers: timeout ----
        for (int i = 1; i <= TIMEOUT; i++) begin
            cycle();
            if (i == TIMEOUT - 1) chk("tmo_err_early", 16'(err), 16'd0);
            if (i == TIMEOUT)     chk("tmo_err", 16'(err), 16'd1);
        end
        chk("tmo_data", data_out, 16'h0005);
        found = 1'b0;
        for (int i = 0; i < 2 * TICK_DIV && !found; i++) begin
            cycle();
            if (f_en) found = 1'b1;
        end
        chk("tmo_restrobe", 16'(found), 16'd1);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        chk("stop_state", 16'(state), 16'd0);
        chk("stop_err_kept", 16'(err), 16'd1);
        start = 1'b1;
        cycle();
        chk("start_err_clr", 16'(err), 16'd0);
        chk("start_state", 16'(state), 16'd1);

        // ---- pause at tick count 2, resume ----
        start = 1'b0;
        cycle();
        cycle();
        pause = 1'b1;
        cycle();
        chk("pause_state", 16'(state), 16'd2);
        pause = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("pause_hold", 16'({state, t_en, f_en}), 16'b1000);
        end
        pause = 1'b1;
        cycle();
        pause = 1'b0;
        chk("resume_state", 16'(state), 16'd1);
        chk("resume_en0", 16'({t_en, f_en}), 16'd0);
        cycle();
        chk("resume_en1", 16'({t_en, f_en}), 16'd1);

        // ---- stop and sel together, valids in IDLE ----
        stop = 1'b1; sel = 1'b1;
        cycle();
        stop = 1'b0; sel = 1'b0;
        chk("stopsel_state", 16'(state), 16'd0);
        chk("stopsel_active", 16'(active), 16'd1);
        t_valid = 1'b1; t_out = 16'hdead;
        f_valid = 1'b1; f_out = 16'hbeef;
        cycle();
        chk("idle_valid_data", data_out, 16'h0005);
        chk("idle_valid_dv", 16'(data_valid), 16'd0);
        t_valid = 1'b0; f_valid = 1'b0;
        cycle();

        // ---- reset mid-RUN with start held ----
        start = 1'b1;
        cycle();
        chk("rr_run", 16'(state), 16'd1);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rr_state", 16'(state), 16'd0);
        chk("rr_data", data_out, 16'h0000);
        chk("rr_flags", 16'({active, err, t_en, f_en, data_valid}), 16'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rr_held", 16'(state), 16'd0);
        end
        start = 1'b0;
        cycle();
        chk("rr_release", 16'(state), 16'd0);
        start = 1'b1;
        cycle();
        chk("rr_press", 16'(state), 16'd1);
        start = 1'b0;

        // ---- randomized run against the model ----
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5)  == 0) start = ~start;
            if ($urandom_range(0, 23) == 0) stop  = ~stop;
            if ($urandom_range(0, 11) == 0) pause = ~pause;
            if ($urandom_range(0, 11) == 0) sel   = ~sel;
            t_valid = ($urandom_range(0, 3) == 0);
            f_valid = ($urandom_range(0, 3) == 0);
            t_out   = 16'($urandom_range(0, 65535));
            f_out   = 16'($urandom_range(0, 65535));
            rst     = ($urandom_range(0, 599) == 0);
            cycle();
        end
        rst = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
